// File: rtl/tri_raster_pkg.sv
// Shared state encoding, default screen geometry and min/max helpers for the triangle raster scheduler.
package tri_raster_pkg;

    localparam int unsigned SCREEN_W_DEF = 1280;
    localparam int unsigned SCREEN_H_DEF = 720;
    localparam int unsigned WIDE_W       = 64;

    typedef logic [WIDE_W-1:0] wide_t;

    typedef enum logic [2:0] {
        IDLE,
        BBOX,
        ISSUE,
        WAIT,
        EMIT,
        ADV,
        DONE
    } state_t;

    function automatic wide_t min3(input wide_t a, input wide_t b, input wide_t c);
        wide_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic wide_t max3(input wide_t a, input wide_t b, input wide_t c);
        wide_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bbox_clamp.sv
// Combinational bounding box of three vertices, upper corner clamped to the screen, plus an off-screen flag.
module bbox_clamp
    import tri_raster_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
    input  logic [W-1:0] ax,
    input  logic [W-1:0] ay,
    input  logic [W-1:0] bx,
    input  logic [W-1:0] by,
    input  logic [W-1:0] cx,
    input  logic [W-1:0] cy,
    output logic [W-1:0] xmin_c,
    output logic [W-1:0] xmax_c,
    output logic [W-1:0] ymin_c,
    output logic [W-1:0] ymax_c,
    output logic         empty_c
);

    localparam logic [W-1:0] X_LIM = W'(SCREEN_W - 1);
    localparam logic [W-1:0] Y_LIM = W'(SCREEN_H - 1);

    logic [W-1:0] xmax_raw;
    logic [W-1:0] ymax_raw;

    always_comb begin
        xmin_c   = W'(min3(WIDE_W'(ax), WIDE_W'(bx), WIDE_W'(cx)));
        ymin_c   = W'(min3(WIDE_W'(ay), WIDE_W'(by), WIDE_W'(cy)));
        xmax_raw = W'(max3(WIDE_W'(ax), WIDE_W'(bx), WIDE_W'(cx)));
        ymax_raw = W'(max3(WIDE_W'(ay), WIDE_W'(by), WIDE_W'(cy)));
        xmax_c   = (xmax_raw > X_LIM) ? X_LIM : xmax_raw;
        ymax_c   = (ymax_raw > Y_LIM) ? Y_LIM : ymax_raw;
        // Once xmin is on screen the clamp can never push xmax below it.
        empty_c  = (xmin_c > X_LIM) || (ymin_c > Y_LIM);
    end

endmodule

// File: rtl/tri_raster_sched.sv
// Triangle raster scheduler: walks the clamped bounding box in raster order, keeps one point test
// in flight at the external tester, and streams covered pixels out over valid/ready.
module tri_raster_sched
    import tri_raster_pkg::*;
#(
    parameter int unsigned SYS_BIT_WIDTH = 32,
    parameter int unsigned SCREEN_W      = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H      = SCREEN_H_DEF,
    parameter int unsigned TIMEOUT       = 15
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     tri_valid_in,
    output logic                     tri_ready_out,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_ax_in,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_ay_in,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_bx_in,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_by_in,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_cx_in,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_cy_in,
    output logic [SYS_BIT_WIDTH-1:0] vertex_ax_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_ay_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_bx_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_by_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_cx_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_cy_out,
    output logic                     test_valid_out,
    output logic [SYS_BIT_WIDTH-1:0] test_x_out,
    output logic [SYS_BIT_WIDTH-1:0] test_y_out,
    input  logic                     test_valid_in,
    input  logic                     test_inside_in,
    output logic                     pix_valid_out,
    input  logic                     pix_ready_in,
    output logic [SYS_BIT_WIDTH-1:0] pix_x_out,
    output logic [SYS_BIT_WIDTH-1:0] pix_y_out,
    output logic                     done_out,
    output logic                     timeout_err_out
);

    localparam int unsigned W     = SYS_BIT_WIDTH;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t         state_q, state_d;
    logic [W-1:0]   ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
    logic [W-1:0]   ax_d, ay_d, bx_d, by_d, cx_d, cy_d;
    logic [W-1:0]   xmin_q, xmax_q, ymax_q;
    logic [W-1:0]   xmin_d, xmax_d, ymax_d;
    logic [W-1:0]   cur_x_q, cur_y_q, cur_x_d, cur_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           tri_ready_q, tri_ready_d;
    logic           test_valid_q, test_valid_d;
    logic           pix_valid_q, pix_valid_d;
    logic           done_q, done_d;

    logic [W-1:0]   bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic           bb_empty;

    bbox_clamp #(
        .W        (W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_bbox (
        .ax      (ax_q),
        .ay      (ay_q),
        .bx      (bx_q),
        .by      (by_q),
        .cx      (cx_q),
        .cy      (cy_q),
        .xmin_c  (bb_xmin),
        .xmax_c  (bb_xmax),
        .ymin_c  (bb_ymin),
        .ymax_c  (bb_ymax),
        .empty_c (bb_empty)
    );

    // Next-state and next-output logic; every registered output is a function of the next state.
    always_comb begin
        state_d = state_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        bx_d    = bx_q;
        by_d    = by_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymax_d  = ymax_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (tri_valid_in && tri_ready_q) begin
                    ax_d    = vertex_ax_in;
                    ay_d    = vertex_ay_in;
                    bx_d    = vertex_bx_in;
                    by_d    = vertex_by_in;
                    cx_d    = vertex_cx_in;
                    cy_d    = vertex_cy_in;
                    err_d   = 1'b0;
                    state_d = BBOX;
                end
            end
            BBOX: begin
                xmin_d = bb_xmin;
                xmax_d = bb_xmax;
                ymax_d = bb_ymax;
                if (bb_empty) begin
                    state_d = DONE;
                end else begin
                    cur_x_d = bb_xmin;
                    cur_y_d = bb_ymin;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A response on the final allowed cycle still wins over the timeout.
                if (test_valid_in) begin
                    state_d = test_inside_in ? EMIT : ADV;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ADV;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EMIT: begin
                if (pix_ready_in) begin
                    state_d = ADV;
                end
            end
            ADV: begin
                if (cur_x_q < xmax_q) begin
                    cur_x_d = cur_x_q + W'(1);
                    state_d = ISSUE;
                end else if (cur_y_q < ymax_q) begin
                    cur_x_d = xmin_q;
                    cur_y_d = cur_y_q + W'(1);
                    state_d = ISSUE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tri_ready_d  = (state_d == IDLE);
        test_valid_d = (state_d == ISSUE);
        pix_valid_d  = (state_d == EMIT);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            ax_q         <= '0;
            ay_q         <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            xmin_q       <= '0;
            xmax_q       <= '0;
            ymax_q       <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            tri_ready_q  <= 1'b1;
            test_valid_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ax_q         <= ax_d;
            ay_q         <= ay_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            xmin_q       <= xmin_d;
            xmax_q       <= xmax_d;
            ymax_q       <= ymax_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            tri_ready_q  <= tri_ready_d;
            test_valid_q <= test_valid_d;
            pix_valid_q  <= pix_valid_d;
            done_q       <= done_d;
        end
    end

    assign tri_ready_out   = tri_ready_q;
    assign test_valid_out  = test_valid_q;
    assign pix_valid_out   = pix_valid_q;
    assign done_out        = done_q;
    assign timeout_err_out = err_q;
    assign test_x_out      = cur_x_q;
    assign test_y_out      = cur_y_q;
    assign pix_x_out       = cur_x_q;
    assign pix_y_out       = cur_y_q;
    assign vertex_ax_out   = ax_q;
    assign vertex_ay_out   = ay_q;
    assign vertex_bx_out   = bx_q;
    assign vertex_by_out   = by_q;
    assign vertex_cx_out   = cx_q;
    assign vertex_cy_out   = cy_q;

endmodule

// File: tb/tb_tri_raster_sched.sv
// Bench for tri_raster_sched: behavioural cross-product tester with fixed latency and a pixel scoreboard.
`timescale 1ns/1ps
module tb_tri_raster_sched;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = 3;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } pix_t;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         tri_valid_in;
    logic         tri_ready_out;
    logic [W-1:0] vertex_ax_in, vertex_ay_in, vertex_bx_in, vertex_by_in, vertex_cx_in, vertex_cy_in;
    logic [W-1:0] vertex_ax_out, vertex_ay_out, vertex_bx_out, vertex_by_out, vertex_cx_out, vertex_cy_out;
    logic         test_valid_out;
    logic [W-1:0] test_x_out, test_y_out;
    logic         test_valid_in;
    logic         test_inside_in;
    logic         pix_valid_out;
    logic         pix_ready_in;
    logic [W-1:0] pix_x_out, pix_y_out;
    logic         done_out;
    logic         timeout_err_out;

    pix_t exp_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_tests   = 0;
    int   done_cnt  = 0;
    int   pop_cnt   = 0;
    int   ready_mode = 0;
    int   late_req  = 0;
    bit   noresp_en = 1'b0;
    int   noresp_x  = 0;
    int   noresp_y  = 0;

    tri_raster_sched #(
        .SYS_BIT_WIDTH (W),
        .SCREEN_W      (1280),
        .SCREEN_H      (720),
        .TIMEOUT       (15)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .tri_valid_in    (tri_valid_in),
        .tri_ready_out   (tri_ready_out),
        .vertex_ax_in    (vertex_ax_in),
        .vertex_ay_in    (vertex_ay_in),
        .vertex_bx_in    (vertex_bx_in),
        .vertex_by_in    (vertex_by_in),
        .vertex_cx_in    (vertex_cx_in),
        .vertex_cy_in    (vertex_cy_in),
        .vertex_ax_out   (vertex_ax_out),
        .vertex_ay_out   (vertex_ay_out),
        .vertex_bx_out   (vertex_bx_out),
        .vertex_by_out   (vertex_by_out),
        .vertex_cx_out   (vertex_cx_out),
        .vertex_cy_out   (vertex_cy_out),
        .test_valid_out  (test_valid_out),
        .test_x_out      (test_x_out),
        .test_y_out      (test_y_out),
        .test_valid_in   (test_valid_in),
        .test_inside_in  (test_inside_in),
        .pix_valid_out   (pix_valid_out),
        .pix_ready_in    (pix_ready_in),
        .pix_x_out       (pix_x_out),
        .pix_y_out       (pix_y_out),
        .done_out        (done_out),
        .timeout_err_out (timeout_err_out)
    );

    initial forever #5 clk_in = ~clk_in;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    function automatic longint edge_fn(input longint x0, input longint y0, input longint x1,
                                       input longint y1, input longint px, input longint py);
        return (x1 - x0) * (py - y0) - (y1 - y0) * (px - x0);
    endfunction

    function automatic bit tri_inside(input longint ax, input longint ay, input longint bx,
                                      input longint by, input longint cx, input longint cy,
                                      input longint px, input longint py);
        longint e0, e1, e2;
        e0 = edge_fn(ax, ay, bx, by, px, py);
        e1 = edge_fn(bx, by, cx, cy, px, py);
        e2 = edge_fn(cx, cy, ax, ay, px, py);
        return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
    endfunction

    // Behavioural tester: answers LAT cycles after a launch, optionally stays silent on one point.
    initial begin
        int     late_done;
        longint tx, ty;
        bit     ins;
        late_done      = 0;
        test_valid_in  = 1'b0;
        test_inside_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (late_req != late_done) begin
                late_done      = late_req;
                test_valid_in  = 1'b1;
                test_inside_in = 1'b1;
                @(negedge clk_in);
                test_valid_in  = 1'b0;
                test_inside_in = 1'b0;
            end else if (test_valid_out) begin
                tx = longint'(test_x_out);
                ty = longint'(test_y_out);
                if (noresp_en && tx == longint'(noresp_x) && ty == longint'(noresp_y)) begin
                    repeat (15) @(negedge clk_in);
                    check("err_before_timeout", longint'(timeout_err_out), 0);
                    @(negedge clk_in);
                    check("err_at_timeout", longint'(timeout_err_out), 1);
                end else begin
                    ins = tri_inside(longint'(vertex_ax_out), longint'(vertex_ay_out),
                                     longint'(vertex_bx_out), longint'(vertex_by_out),
                                     longint'(vertex_cx_out), longint'(vertex_cy_out), tx, ty);
                    repeat (LAT - 1) @(negedge clk_in);
                    test_valid_in  = 1'b1;
                    test_inside_in = ins;
                    @(negedge clk_in);
                    test_valid_in  = 1'b0;
                    test_inside_in = 1'b0;
                end
            end
        end
    end

    // Downstream ready pattern: 0 always ready, 1 ready one cycle in three, else never.
    initial begin
        int rcyc;
        rcyc         = 0;
        pix_ready_in = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            rcyc++;
            case (ready_mode)
                0:       pix_ready_in = 1'b1;
                1:       pix_ready_in = (rcyc % 3 == 0);
                default: pix_ready_in = 1'b0;
            endcase
        end
    end

    // Monitor: counts tests and done pulses, checks stall stability, pops the scoreboard per handshake.
    initial begin
        bit           stalled;
        logic [W-1:0] sx, sy;
        pix_t         e;
        stalled = 1'b0;
        sx      = '0;
        sy      = '0;
        forever begin
            @(negedge clk_in);
            if (test_valid_out) begin
                n_tests++;
                check("test_on_screen", longint'(test_x_out <= 1279 && test_y_out <= 719), 1);
            end
            if (done_out) done_cnt++;
            if (pix_valid_out) begin
                if (stalled) begin
                    check("stall_hold_x", longint'(pix_x_out), longint'(sx));
                    check("stall_hold_y", longint'(pix_y_out), longint'(sy));
                end
                if (pix_ready_in) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL pix_unexpected: actual (%0d,%0d) required none", pix_x_out, pix_y_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("pix_x", longint'(pix_x_out), longint'(e.x));
                        check("pix_y", longint'(pix_y_out), longint'(e.y));
                    end
                    pop_cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    sx      = pix_x_out;
                    sy      = pix_y_out;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    // Covered pixels of (2,2),(6,2),(2,6): x,y >= 2 and x+y <= 8, raster order, optionally minus one.
    task automatic push_tri_a(input int skip_x, input int skip_y);
        pix_t p;
        for (int y = 2; y <= 6; y++) begin
            for (int x = 2; x <= 6; x++) begin
                if (x + y <= 8 && !(x == skip_x && y == skip_y)) begin
                    p.x = W'(x);
                    p.y = W'(y);
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    task automatic send_tri(input int ax, input int ay, input int bx, input int by,
                            input int cx, input int cy);
        @(negedge clk_in);
        check("tri_ready_idle", longint'(tri_ready_out), 1);
        vertex_ax_in = W'(ax);
        vertex_ay_in = W'(ay);
        vertex_bx_in = W'(bx);
        vertex_by_in = W'(by);
        vertex_cx_in = W'(cx);
        vertex_cy_in = W'(cy);
        tri_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        tri_valid_in = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input int start);
        int n;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check(name, longint'(done_cnt - start), 1);
        repeat (3) @(negedge clk_in);
        check("tri_ready_after_done", longint'(tri_ready_out), 1);
        check("single_done", longint'(done_cnt - start), 1);
        check("scoreboard_drained", longint'(exp_q.size()), 0);
    endtask

    initial begin
        int t0, d0, p0, n;
        rst_in       = 1'b0;
        tri_valid_in = 1'b0;
        vertex_ax_in = '0;
        vertex_ay_in = '0;
        vertex_bx_in = '0;
        vertex_by_in = '0;
        vertex_cx_in = '0;
        vertex_cy_in = '0;
        repeat (3) @(negedge clk_in);
        check("rst_tri_ready", longint'(tri_ready_out), 1);
        check("rst_test_valid", longint'(test_valid_out), 0);
        check("rst_pix_valid", longint'(pix_valid_out), 0);
        check("rst_done", longint'(done_out), 0);
        check("rst_err", longint'(timeout_err_out), 0);
        check("rst_pix_x", longint'(pix_x_out), 0);
        rst_in = 1'b1;

        // Basic scan, always ready.
        push_tri_a(-1, -1);
        t0 = n_tests; d0 = done_cnt; p0 = pop_cnt;
        send_tri(2, 2, 6, 2, 2, 6);
        wait_done("done_tri_a", 3000, d0);
        check("tests_tri_a", longint'(n_tests - t0), 25);
        check("pixels_tri_a", longint'(pop_cnt - p0), 15);

        // Same triangle under backpressure.
        ready_mode = 1;
        push_tri_a(-1, -1);
        t0 = n_tests; d0 = done_cnt; p0 = pop_cnt;
        send_tri(2, 2, 6, 2, 2, 6);
        wait_done("done_tri_a_bp", 3000, d0);
        check("tests_tri_a_bp", longint'(n_tests - t0), 25);
        check("pixels_tri_a_bp", longint'(pop_cnt - p0), 15);
        ready_mode = 0;

        // Fully off-screen box.
        t0 = n_tests; d0 = done_cnt;
        send_tri(1300, 10, 1400, 20, 1350, 30);
        @(negedge clk_in);
        check("offscreen_done_early", longint'(done_out), 0);
        @(negedge clk_in);
        check("offscreen_done_pulse", longint'(done_out), 1);
        repeat (3) @(negedge clk_in);
        check("offscreen_tests", longint'(n_tests - t0), 0);
        check("offscreen_single_done", longint'(done_cnt - d0), 1);

        // Box crossing the bottom-right corner: 1270..1279 x 700..719.
        for (int y = 700; y <= 719; y++) begin
            for (int x = 1270; x <= 1279; x++) begin
                if (tri_inside(1279, 719, 1270, 710, 1290, 700, longint'(x), longint'(y))) begin
                    exp_q.push_back('{x: W'(x), y: W'(y)});
                end
            end
        end
        t0 = n_tests; d0 = done_cnt;
        send_tri(1279, 719, 1270, 710, 1290, 700);
        wait_done("done_clamp", 8000, d0);
        check("tests_clamp", longint'(n_tests - t0), 200);

        // Silent tester on (3,3): that pixel is dropped, scan carries on.
        noresp_en = 1'b1; noresp_x = 3; noresp_y = 3;
        push_tri_a(3, 3);
        t0 = n_tests; d0 = done_cnt; p0 = pop_cnt;
        send_tri(2, 2, 6, 2, 2, 6);
        wait_done("done_timeout", 3000, d0);
        noresp_en = 1'b0;
        check("tests_timeout", longint'(n_tests - t0), 25);
        check("pixels_timeout", longint'(pop_cnt - p0), 14);
        check("err_sticky", longint'(timeout_err_out), 1);

        // Degenerate single point; also clears the sticky error.
        exp_q.push_back('{x: W'(10), y: W'(10)});
        t0 = n_tests; d0 = done_cnt;
        send_tri(10, 10, 10, 10, 10, 10);
        @(negedge clk_in);
        check("err_cleared", longint'(timeout_err_out), 0);
        wait_done("done_degen", 500, d0);
        check("tests_degen", longint'(n_tests - t0), 1);

        // Reset while the third pixel is being emitted.
        push_tri_a(-1, -1);
        p0 = pop_cnt;
        send_tri(2, 2, 6, 2, 2, 6);
        for (n = 0; n < 500; n++) begin
            @(posedge clk_in);
            #1;
            if (pix_valid_out && pop_cnt == p0 + 2) break;
        end
        check("third_emit_found", longint'(n < 500), 1);
        rst_in = 1'b0;
        #1;
        check("midrst_pix_valid", longint'(pix_valid_out), 0);
        check("midrst_tri_ready", longint'(tri_ready_out), 1);
        check("midrst_vertex", longint'(vertex_ax_out), 0);
        check("midrst_pix_x", longint'(pix_x_out), 0);
        exp_q.delete();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        late_req++;
        repeat (4) @(negedge clk_in);
        check("late_resp_tri_ready", longint'(tri_ready_out), 1);
        check("late_resp_pix_valid", longint'(pix_valid_out), 0);
        check("late_resp_test_valid", longint'(test_valid_out), 0);

        ready_mode = 1;
        push_tri_a(-1, -1);
        t0 = n_tests; d0 = done_cnt; p0 = pop_cnt;
        send_tri(2, 2, 6, 2, 2, 6);
        wait_done("done_after_rst", 3000, d0);
        check("tests_after_rst", longint'(n_tests - t0), 25);
        check("pixels_after_rst", longint'(pop_cnt - p0), 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
